// File: rtl/ex_stage_pkg.sv
// Execute-stage output bundle consumed by the load/store unit.
// wb_sel selects the writeback source for the instruction.
package ex_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] opr_res;
    logic [XLEN-1:0] opr_b;
    logic [4:0]      rd;
    logic            rf_en;
    logic            dm_en;
    logic [1:0]      wb_sel;
  } ex_stage_out_t;

endpackage

// File: rtl/lsu_pkg.sv
// Types shared by the load/store unit: FSM states, memory-writeback select, writeback bundle.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [1:0] WB_MEM = ex_stage_pkg::WB_SEL_MEM;

  typedef struct packed {
    logic [4:0]                   rd;
    logic                         rf_en;
    logic [ex_stage_pkg::XLEN-1:0] data;
  } wb_bundle_t;

endpackage

// File: rtl/lsu.sv
// Load/store unit: ALU ops write back after 1 cycle; loads/stores go through a valid/ready memory bus.
// in_ready is low while a memory op is outstanding; the writeback side never stalls.
module lsu
  import ex_stage_pkg::*, lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  ex_stage_pkg::ex_stage_out_t   ex_in,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic                          req_we,
  output logic [ADDR_WIDTH-1:0]         req_addr,
  output logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic                          rsp_valid,
  input  logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          wb_valid,
  output logic [4:0]                    wb_rd,
  output logic                          wb_rf_en,
  output logic [DATA_WIDTH-1:0]         wb_data
);

  lsu_state_t state, state_nxt;
  logic       accept, is_store, is_load, is_mem, req_fire;
  logic [4:0] cap_rd;
  logic       cap_rf_en;
  wb_bundle_t wb_q, wb_nxt;
  logic       wb_vld_nxt;

  assign accept   = in_valid && in_ready;
  assign is_store = ex_in.dm_en;
  assign is_load  = !ex_in.dm_en && (ex_in.wb_sel == WB_MEM);
  assign is_mem   = is_store || is_load;
  assign req_fire = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem) state_nxt = REQ;
      REQ:     if (req_fire)         state_nxt = req_we ? IDLE : WAIT;
      WAIT:    if (rsp_valid)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    req_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      REQ:     req_valid = 1'b1;
      default: ;
    endcase
  end

  // Stores complete on request acceptance; they carry no register write.
  always_comb begin
    wb_vld_nxt = 1'b0;
    wb_nxt     = wb_q;
    if (accept && !is_mem) begin
      wb_vld_nxt = 1'b1;
      wb_nxt     = '{rd: ex_in.rd, rf_en: ex_in.rf_en, data: ex_in.opr_res};
    end else if (state == REQ && req_fire && req_we) begin
      wb_vld_nxt = 1'b1;
      wb_nxt     = '{rd: cap_rd, rf_en: 1'b0, data: '0};
    end else if (state == WAIT && rsp_valid) begin
      wb_vld_nxt = 1'b1;
      wb_nxt     = '{rd: cap_rd, rf_en: cap_rf_en, data: rsp_rdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid  <= 1'b0;
      wb_q      <= '0;
      cap_rd    <= '0;
      cap_rf_en <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      wb_valid <= wb_vld_nxt;
      wb_q     <= wb_nxt;
      if (accept) begin
        cap_rd    <= ex_in.rd;
        cap_rf_en <= ex_in.rf_en;
      end
      // Request fields only move on a new memory op so they hold outside REQ.
      if (accept && is_mem) begin
        req_we    <= is_store;
        req_addr  <= {ex_in.opr_res[ADDR_WIDTH-1:2], 2'b00};
        req_wdata <= ex_in.opr_b;
      end
    end
  end

  assign wb_rd    = wb_q.rd;
  assign wb_rf_en = wb_q.rf_en;
  assign wb_data  = wb_q.data;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: ALU stream, store/load handshakes, spurious responses, store priority, reset.
module tb_lsu;
  import ex_stage_pkg::*;
  import lsu_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  ex_stage_out_t ex_in;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          wb_rf_en;
  logic [31:0]   wb_data;

  int n_assert = 0;
  int n_fail   = 0;

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ex_in     (ex_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_rf_en  (wb_rf_en),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [31:0] res, input logic [31:0] b, input logic [4:0] rd,
                        input logic rf, input logic dm, input logic [1:0] sel);
    ex_in.opr_res = res;
    ex_in.opr_b   = b;
    ex_in.rd      = rd;
    ex_in.rf_en   = rf;
    ex_in.dm_en   = dm;
    ex_in.wb_sel  = sel;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    chk({tag, "_req_we"},    32'(req_we),    32'd0);
    chk({tag, "_req_addr"},  req_addr,       32'd0);
    chk({tag, "_req_wdata"}, req_wdata,      32'd0);
    chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
    chk({tag, "_wb_rd"},     32'(wb_rd),     32'd0);
    chk({tag, "_wb_rf_en"},  32'(wb_rf_en),  32'd0);
    chk({tag, "_wb_data"},   wb_data,        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    set_ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, WB_SEL_ALU);
    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // ALU stream: three back-to-back ops
    in_valid = 1'b1;
    set_ex(32'h11, 32'h0, 5'd5, 1'b1, 1'b0, WB_SEL_ALU);
    tick();
    chk("alu0_vld", 32'(wb_valid), 32'd1);
    chk("alu0_data", wb_data, 32'h11);
    chk("alu0_rd", 32'(wb_rd), 32'd5);
    chk("alu0_rf_en", 32'(wb_rf_en), 32'd1);
    chk("alu0_rdy", 32'(in_ready), 32'd1);
    set_ex(32'h22, 32'h0, 5'd6, 1'b1, 1'b0, WB_SEL_ALU);
    tick();
    chk("alu1_vld", 32'(wb_valid), 32'd1);
    chk("alu1_data", wb_data, 32'h22);
    chk("alu1_rd", 32'(wb_rd), 32'd6);
    chk("alu1_rdy", 32'(in_ready), 32'd1);
    set_ex(32'h33, 32'h0, 5'd7, 1'b1, 1'b0, WB_SEL_PC4);
    tick();
    chk("alu2_vld", 32'(wb_valid), 32'd1);
    chk("alu2_data", wb_data, 32'h33);
    chk("alu2_rd", 32'(wb_rd), 32'd7);
    chk("alu2_req_valid", 32'(req_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("alu_end_vld", 32'(wb_valid), 32'd0);

    // Store with req_ready low for two cycles
    in_valid = 1'b1;
    set_ex(32'h1003, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1, WB_SEL_ALU);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req_ready = 1'b1;
      chk($sformatf("st_req_valid_c%0d", c), 32'(req_valid), 32'd1);
      chk($sformatf("st_req_we_c%0d", c), 32'(req_we), 32'd1);
      chk($sformatf("st_req_addr_c%0d", c), req_addr, 32'h1000);
      chk($sformatf("st_req_wdata_c%0d", c), req_wdata, 32'hDEADBEEF);
      chk($sformatf("st_in_ready_c%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("st_wb_idle_c%0d", c), 32'(wb_valid), 32'd0);
      if (c < 2) tick();
    end
    tick();
    req_ready = 1'b0;
    chk("st_wb_vld", 32'(wb_valid), 32'd1);
    chk("st_wb_rf_en", 32'(wb_rf_en), 32'd0);
    chk("st_wb_data", wb_data, 32'd0);
    chk("st_in_ready", 32'(in_ready), 32'd1);
    chk("st_req_drop", 32'(req_valid), 32'd0);
    chk("st_addr_hold", req_addr, 32'h1000);
    tick();
    chk("st_wb_pulse_end", 32'(wb_valid), 32'd0);

    // Load with response on the fourth cycle after request acceptance
    in_valid = 1'b1;
    set_ex(32'h2000, 32'h0, 5'd10, 1'b1, 1'b0, WB_MEM);
    tick();
    in_valid  = 1'b0;
    req_ready = 1'b1;
    chk("ld_req_valid", 32'(req_valid), 32'd1);
    chk("ld_req_we", 32'(req_we), 32'd0);
    chk("ld_req_addr", req_addr, 32'h2000);
    tick();
    req_ready = 1'b0;
    chk("ld_wait_req_valid", 32'(req_valid), 32'd0);
    chk("ld_wait_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("ld_wait_wb_c%0d", c), 32'(wb_valid), 32'd0);
    end
    rsp_valid = 1'b1;
    rsp_rdata = 32'hCAFEF00D;
    chk("ld_pre_rsp_wb", 32'(wb_valid), 32'd0);
    tick();
    rsp_valid = 1'b0;
    chk("ld_wb_vld", 32'(wb_valid), 32'd1);
    chk("ld_wb_data", wb_data, 32'hCAFEF00D);
    chk("ld_wb_rd", 32'(wb_rd), 32'd10);
    chk("ld_wb_rf_en", 32'(wb_rf_en), 32'd1);
    chk("ld_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("ld_wb_pulse_end", 32'(wb_valid), 32'd0);

    // Spurious responses in IDLE and in REQ
    rsp_valid = 1'b1;
    rsp_rdata = 32'hBAD0BAD0;
    tick();
    rsp_valid = 1'b0;
    chk("sp_idle_wb", 32'(wb_valid), 32'd0);
    chk("sp_idle_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    set_ex(32'h3000, 32'h0, 5'd11, 1'b1, 1'b0, WB_MEM);
    tick();
    in_valid  = 1'b0;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("sp_req_wb", 32'(wb_valid), 32'd0);
    chk("sp_req_still_req", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("sp_wait_wb", 32'(wb_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_rdata = 32'h12345678;
    tick();
    rsp_valid = 1'b0;
    chk("sp_ld_wb_vld", 32'(wb_valid), 32'd1);
    chk("sp_ld_wb_data", wb_data, 32'h12345678);
    chk("sp_ld_wb_rd", 32'(wb_rd), 32'd11);

    // Store priority: dm_en wins over wb_sel=WB_MEM
    in_valid = 1'b1;
    set_ex(32'h4008, 32'h55AA55AA, 5'd9, 1'b1, 1'b1, WB_MEM);
    tick();
    in_valid  = 1'b0;
    req_ready = 1'b1;
    chk("pri_req_we", 32'(req_we), 32'd1);
    chk("pri_req_addr", req_addr, 32'h4008);
    chk("pri_req_wdata", req_wdata, 32'h55AA55AA);
    tick();
    req_ready = 1'b0;
    chk("pri_wb_vld", 32'(wb_valid), 32'd1);
    chk("pri_wb_rf_en", 32'(wb_rf_en), 32'd0);
    chk("pri_in_ready", 32'(in_ready), 32'd1);

    // Reset while a load waits for its response
    in_valid = 1'b1;
    set_ex(32'h5000, 32'h0, 5'd12, 1'b1, 1'b0, WB_MEM);
    tick();
    in_valid  = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("mr_wait_rdy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mr");
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hFEEDFACE;
    tick();
    rsp_valid = 1'b0;
    chk("mr_late_rsp_wb", 32'(wb_valid), 32'd0);
    chk("mr_late_rsp_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("mr_late_rsp_wb2", 32'(wb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
